fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the core; owns the program counter.
- Issues one outstanding request at a time to instruction memory over a req/gnt/rvalid interface.
- Holds the fetched instruction in a one-entry output buffer for decode, using a valid/ready handshake.
- Consumes the redirect produced in execute (branch unit taken output, jumps) and discards any stale in-flight fetch.

Parameters:
XLEN, 32, width of PC, addresses and instruction word.
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_INST, 32'h0000_0013, value driven on inst_o while no valid instruction is held (addi x0,x0,0).

Ports:
clk_i  input  1  clock, all state updates on the rising edge.
rstn_i  input  1  reset, asynchronous, active-low.
redirect_i  input  1  one-cycle pulse from execute: branch taken or jump.
redirect_pc_i  input  XLEN  target address, valid when redirect_i=1; bits [1:0] are ignored and forced to zero.
imem_req_o  input/output: output  1  fetch request valid.
imem_addr_o  output  XLEN  fetch address, word aligned.
imem_gnt_i  input  1  memory accepted the request this cycle.
imem_rvalid_i  input  1  read data valid, one cycle per granted request.
imem_rdata_i  input  XLEN  fetched instruction.
inst_valid_o  output  1  output buffer holds an instruction.
inst_o  output  XLEN  instruction to decode.
inst_pc_o  output  XLEN  address of inst_o.
inst_ready_i  input  1  decode accepts the instruction this cycle.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - state=IDLE, pc=RESET_PC, drop=0.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=RESET_PC.
  - A response arriving after reset for a pre-reset request is ignored, because rvalid is only sampled in WAIT.
- All outputs are registered or decoded from state; there is no combinational path from input to output.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: lasts one cycle after reset release, then goes to REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc. On imem_gnt_i, go to WAIT. Without a grant, stay in REQ; address and req stay stable until granted (bus rule).
  - WAIT: imem_req_o=0. On imem_rvalid_i:
    - drop=0: inst_o<=imem_rdata_i, inst_pc_o<=pc, inst_valid_o<=1, pc<=pc+4 (wraps modulo 2^XLEN), go to HOLD.
    - drop=1: discard the data, drop<=0, go to REQ.
  - HOLD: inst_valid_o=1. When inst_ready_i=1: inst_valid_o<=0, inst_o<=NOP_INST, go to REQ. Otherwise hold all values stable.
- Minimum latency: grant in the same cycle as req plus rvalid one cycle later gives inst_valid_o 2 cycles after entering REQ. Steady throughput is one instruction per 3 cycles with zero-wait memory and decode always ready.
- Redirect (highest priority; evaluated in the same cycle as the events below):
  - IDLE: pc<=target; state goes to REQ.
  - REQ, no grant this cycle: the request in flight keeps its old address (stability rule). Set drop<=1 and pc<=target. The later response is discarded, then the target is fetched.
  - REQ, grant this cycle: drop<=1, pc<=target, go to WAIT.
  - WAIT, no rvalid: drop<=1, pc<=target.
  - WAIT, rvalid this cycle: discard the data, drop<=0, pc<=target, go to REQ.
  - HOLD: inst_valid_o<=0, inst_o<=NOP_INST, pc<=target, go to REQ. If inst_ready_i=1 in the same cycle, the handshake still counts as completed (decode consumed it); the buffer is cleared either way.
  - Two redirects before a dropped response returns: the last target wins, and only one response is discarded.
- drop is set only while a granted-or-pending request is outstanding; it is cleared only on a consumed rvalid.
- imem_rvalid_i outside WAIT: ignored.

Test Plan:
- Reset then run, zero-wait memory with gnt in the same cycle and rvalid next cycle, inst_ready_i=1 -> addresses 0x0, 0x4, 0x8 requested; inst_valid_o pulses carry inst_pc_o 0x0, 0x4, 0x8 with the matching rdata.
- Decode stall: inst_ready_i=0 for 5 cycles with the buffer full -> inst_o and inst_pc_o stable, imem_req_o=0 throughout; fetch of the next PC starts the cycle after ready rises.
- Redirect to 0x100 in WAIT, with rvalid 3 cycles later carrying 0xDEADBEEF -> data discarded, inst_valid_o never asserts for it; next request address 0x100.
- Redirect to 0x203 in REQ with gnt withheld 2 cycles -> imem_addr_o keeps the old PC until grant; that response is dropped; next request address is 0x200.
- Redirect in HOLD with inst_ready_i=1 in the same cycle -> inst_valid_o=0 next cycle, next request address is the target, no duplicate instruction.
- Assert rstn_i low mid-WAIT, then deliver a stray rvalid after release -> outputs at their reset values; first request is to RESET_PC; the stray data never appears on inst_o.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and presents the fetched instruction to decode through a one-entry valid/ready buffer.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            drop_q;
    logic [XLEN-1:0] target;

    // Redirect targets are forced to word alignment.
    assign target = redirect_pc_i & ~XLEN'(3);

    // Fetch FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            imem_req_o   <= 1'b0;
            imem_addr_o  <= RESET_PC;
            inst_valid_o <= 1'b0;
            inst_o       <= NOP_INST;
            inst_pc_o    <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_REQ;
                    imem_req_o <= 1'b1;
                    if (redirect_i) begin
                        pc_q        <= target;
                        imem_addr_o <= target;
                    end else begin
                        imem_addr_o <= pc_q;
                    end
                end

                S_REQ: begin
                    // Address stays on the bus until granted; a redirect only retargets pc.
                    if (redirect_i) begin
                        drop_q <= 1'b1;
                        pc_q   <= target;
                    end
                    if (imem_gnt_i) begin
                        imem_req_o <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (redirect_i || drop_q) begin
                            drop_q      <= 1'b0;
                            state_q     <= S_REQ;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= redirect_i ? target : pc_q;
                            if (redirect_i) begin
                                pc_q <= target;
                            end
                        end else begin
                            inst_o       <= imem_rdata_i;
                            inst_pc_o    <= pc_q;
                            inst_valid_o <= 1'b1;
                            pc_q         <= pc_q + XLEN'(4);
                            state_q      <= S_HOLD;
                        end
                    end else if (redirect_i) begin
                        drop_q <= 1'b1;
                        pc_q   <= target;
                    end
                end

                S_HOLD: begin
                    if (redirect_i || inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                        inst_o       <= NOP_INST;
                        state_q      <= S_REQ;
                        imem_req_o   <= 1'b1;
                        imem_addr_o  <= redirect_i ? target : pc_q;
                        if (redirect_i) begin
                            pc_q <= target;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: a cycle table plus a few hand-written sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_vec;
    int n_bad;

    fetch_unit dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_ready_i (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_inst,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_inst,
                            input logic [31:0] e_pc);
        n_vec++;
        chk({tag, ".req"},   32'(imem_req),   32'(e_req));
        chk({tag, ".addr"},  imem_addr,       e_addr);
        chk({tag, ".valid"}, 32'(inst_valid), 32'(e_valid));
        chk({tag, ".inst"},  inst,            e_inst);
        chk({tag, ".pc"},    inst_pc,         e_pc);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy);
        @(negedge clk);
        rstn = rst; redirect = redir; redirect_pc = rpc; imem_gnt = gnt;
        imem_rvalid = rv; imem_rdata = rdata; inst_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

        //          rst red rpc            gnt rv rdata          rdy | req addr          vld inst           pc
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          0,  0, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          0,  1, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0000,  1,  0, 32'h0,         1, 32'hA000_0000, 32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h4,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h4,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0004,  1,  0, 32'h4,         1, 32'hA000_0004, 32'h4));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h8,         0, NOP,           32'h4));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h8,         0, NOP,           32'h4));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hA000_0008,  0,  0, 32'h8,         1, 32'hA000_0008, 32'h8));
        // decode stall for five cycles
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1, 0, 32'h0,    0, 1, 32'h5555_5555,  0,  0, 32'h8,         1, 32'hA000_0008, 32'h8));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'hC,         0, NOP,           32'h8));
        // redirect in WAIT, stale data three cycles later
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'hC,         0, NOP,           32'h8));
        vq.push_back(mk(1, 1, 32'h100,      0, 0, 32'h0,          1,  0, 32'hC,         0, NOP,           32'h8));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  0, 32'hC,         0, NOP,           32'h8));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  0, 32'hC,         0, NOP,           32'h8));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hDEAD_BEEF,  1,  1, 32'h100,       0, NOP,           32'h8));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h100,       0, NOP,           32'h8));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hB000_0100,  1,  0, 32'h100,       1, 32'hB000_0100, 32'h100));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h104,       0, NOP,           32'h100));
        // redirect to misaligned 0x203 in REQ, grant withheld
        vq.push_back(mk(1, 1, 32'h203,      0, 0, 32'h0,          1,  1, 32'h104,       0, NOP,           32'h100));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h104,       0, NOP,           32'h100));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h104,       0, NOP,           32'h100));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h104,       0, NOP,           32'h100));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hBAD0_0104,  1,  1, 32'h200,       0, NOP,           32'h100));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h200,       0, NOP,           32'h100));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hC000_0200,  1,  0, 32'h200,       1, 32'hC000_0200, 32'h200));
        // redirect in HOLD together with ready
        vq.push_back(mk(1, 1, 32'h300,      0, 0, 32'h0,          1,  1, 32'h300,       0, NOP,           32'h200));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h300,       0, NOP,           32'h200));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hD000_0300,  1,  0, 32'h300,       1, 32'hD000_0300, 32'h300));
        // reset in the middle of WAIT, then stray rvalid
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h304,       0, NOP,           32'h300));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h304,       0, NOP,           32'h300));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1,  0, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hBAD0_BAD0,  1,  1, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hBAD1_BAD1,  1,  1, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h0,         0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hE000_0000,  1,  0, 32'h0,         1, 32'hE000_0000, 32'h0));
        // redirect during the granting cycle of REQ
        vq.push_back(mk(1, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, NOP,           32'h0));
        vq.push_back(mk(1, 1, 32'h400,      1, 0, 32'h0,          1,  0, 32'hFFFF_FFFC, 0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'h0BAD_0BAD,  1,  1, 32'h400,       0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'h400,       0, NOP,           32'h0));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'hF000_0400,  1,  0, 32'h400,       1, 32'hF000_0400, 32'h400));
        // pc wraps from 0xFFFFFFFC to 0
        vq.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, NOP,           32'h400));
        vq.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,          1,  0, 32'hFFFF_FFFC, 0, NOP,           32'h400));
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'h1111_1111,  1,  0, 32'hFFFF_FFFC, 1, 32'h1111_1111, 32'hFFFF_FFFC));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          1,  1, 32'h0,         0, NOP,           32'hFFFF_FFFC));

        #2;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].redir, vq[i].rpc, vq[i].gnt, vq[i].rv, vq[i].rdata, vq[i].rdy);
            chk_outs($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_valid,
                     vq[i].e_inst, vq[i].e_pc);
        end

        // Redirect in IDLE: release reset with a redirect pending.
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1);
        drive(1, 1, 32'h500, 0, 0, 32'h0, 1);
        chk_outs("idle_redirect", 1, 32'h500, 0, NOP, 32'h0);

        // Two redirects while one request is outstanding: only one response is dropped.
        drive(1, 0, 32'h0,   1, 0, 32'h0, 1);
        drive(1, 1, 32'h600, 0, 0, 32'h0, 1);
        drive(1, 1, 32'h704, 0, 0, 32'h0, 1);
        drive(1, 0, 32'h0,   0, 1, 32'hBAD0_0500, 1);
        chk_outs("double_redirect", 1, 32'h704, 0, NOP, 32'h0);

        // Memory with a variable grant delay; wait for the request and grant it, bounded.
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                if (imem_req && c >= 2) begin
                    drive(1, 0, 32'h0, 1, 0, 32'h0, 1);
                    seen = 1'b1;
                end else begin
                    drive(1, 0, 32'h0, 0, 0, 32'h0, 1);
                end
            end
            n_vec++;
            if (!seen) begin
                n_bad++;
                $display("FAIL grant_wait: request never seen within 8 cycles");
            end
        end
        drive(1, 0, 32'h0, 0, 1, 32'h7777_0704, 1);
        chk_outs("after_double", 0, 32'h704, 1, 32'h7777_0704, 32'h704);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 1);
        chk_outs("next_after_double", 1, 32'h708, 0, NOP, 32'h704);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
